// File: rtl/ahb_apb_pkg.sv
// Shared constants and types for the AHB-to-APB bridge: AHB encodings,
// error-response FSM states and the default peripheral address map.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] DEF_SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] DEF_WIN_SIZE  = 32'h0400_0000;

  typedef enum logic [1:0] {
    ST_OKAY = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_e;

  // Window hit test on the bits above the (power-of-two) window size only;
  // base and size are constants, so this reduces to an equality compare.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return ((addr ^ base) & ~(size - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational haddr to one-hot peripheral select for the bridge's slave windows.
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
  parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
  parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
  parameter logic [31:0] WIN_SIZE  = DEF_WIN_SIZE
) (
  input  logic [31:0] haddr,
  output logic [2:0]  temp_sel
);

  localparam logic [2:0][31:0] BASES = {SLV2_BASE, SLV1_BASE, SLV0_BASE};

  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    assign temp_sel[gi] = in_window(haddr, BASES[gi], WIN_SIZE);
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, slave
// decode, free-running address/data/direction delay lines and ERROR response.
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
  parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
  parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
  parameter logic [31:0] WIN_SIZE  = DEF_WIN_SIZE
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hready_in,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        valid,
  output logic [2:0]  temp_sel,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwrite_reg,
  output logic        hwrite_reg1,
  output logic [1:0]  hresp,
  output logic        err_readyout
);

  err_state_e state, state_next;
  logic       active;
  logic       err_req;

  ahb_addr_decode #(
    .SLV0_BASE (SLV0_BASE),
    .SLV1_BASE (SLV1_BASE),
    .SLV2_BASE (SLV2_BASE),
    .WIN_SIZE  (WIN_SIZE)
  ) u_decode (
    .haddr    (haddr),
    .temp_sel (temp_sel)
  );

  assign active  = hresetn && hready_in &&
                   (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign valid   = active && (temp_sel != 3'b000) && (state != ST_ERR1);
  assign err_req = active && (temp_sel == 3'b000);

  // Delay lines run every cycle regardless of hready_in; the controller
  // depends on the fixed 1- and 2-cycle alignment.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_OKAY;
    else          state <= state_next;
  end

  // Two-cycle ERROR: first cycle stalls the master, second completes it.
  always_comb begin
    state_next   = state;
    hresp        = HRESP_OKAY;
    err_readyout = 1'b1;
    case (state)
      ST_OKAY: begin
        if (err_req) state_next = ST_ERR1;
      end
      ST_ERR1: begin
        hresp        = HRESP_ERROR;
        err_readyout = 1'b0;
        state_next   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp      = HRESP_ERROR;
        state_next = err_req ? ST_ERR1 : ST_OKAY;
      end
      default: state_next = ST_OKAY;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed vector table, hand-written
// reset sequences and randomized traffic checked against a cycle-indexed model.
module tb_ahb_slave_if;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        valid;
  logic [2:0]  temp_sel;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
  logic        hwrite_reg, hwrite_reg1;
  logic [1:0]  hresp;
  logic        err_readyout;

  int errors = 0;
  int checks = 0;

  ahb_slave_if dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hwrite       (hwrite),
    .hready_in    (hready_in),
    .htrans       (htrans),
    .haddr        (haddr),
    .hwdata       (hwdata),
    .valid        (valid),
    .temp_sel     (temp_sel),
    .haddr1       (haddr1),
    .haddr2       (haddr2),
    .hwdata1      (hwdata1),
    .hwdata2      (hwdata2),
    .hwrite_reg   (hwrite_reg),
    .hwrite_reg1  (hwrite_reg1),
    .hresp        (hresp),
    .err_readyout (err_readyout)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: address map as plain ranges, error response tracked by
  // the cycle index of the most recently accepted error.
  localparam longint WIN = 64'h0400_0000;
  longint bases [3] = '{64'h8000_0000, 64'h8400_0000, 64'h8800_0000};

  int          cyc;
  int          last_err;
  logic [31:0] m_a1, m_a2, m_d1, m_d2;
  logic        m_w1, m_w2;

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    logic [2:0] s = 3'b000;
    longint ua = longint'(a);
    for (int k = 0; k < 3; k++)
      if (ua >= bases[k] && ua < bases[k] + WIN) s[k] = 1'b1;
    return s;
  endfunction

  function automatic logic ref_active();
    return hresetn && hready_in && (htrans == 2'b10 || htrans == 2'b11);
  endfunction

  task automatic model_reset();
    cyc = 0; last_err = -10;
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w1 = 1'b0; m_w2 = 1'b0;
  endtask

  task automatic model_update();
    if (ref_active() && ref_sel(haddr) == 3'b000 && cyc != last_err + 1)
      last_err = cyc;
    m_a2 = m_a1; m_a1 = haddr;
    m_d2 = m_d1; m_d1 = hwdata;
    m_w2 = m_w1; m_w1 = hwrite;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic in_err1, in_err2;
    logic [2:0] s;
    in_err1 = (cyc == last_err + 1);
    in_err2 = (cyc == last_err + 2);
    s = ref_sel(haddr);
    chk("temp_sel", 32'(temp_sel), 32'(s));
    chk("valid", 32'(valid), 32'(ref_active() && s != 3'b000 && !in_err1));
    chk("hresp", 32'(hresp), (in_err1 || in_err2) ? 32'd1 : 32'd0);
    chk("err_readyout", 32'(err_readyout), 32'(!in_err1));
    chk("haddr1", haddr1, m_a1);
    chk("haddr2", haddr2, m_a2);
    chk("hwdata1", hwdata1, m_d1);
    chk("hwdata2", hwdata2, m_d2);
    chk("hwrite_reg", 32'(hwrite_reg), 32'(m_w1));
    chk("hwrite_reg1", 32'(hwrite_reg1), 32'(m_w2));
  endtask

  // One bus cycle: drive just after the rising edge, check on the falling edge.
  task automatic step(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic r);
    @(posedge hclk);
    #1;
    htrans = t; haddr = a; hwdata = d; hwrite = w; hready_in = r;
    @(negedge hclk);
    $display("cyc=%0d htrans=%b haddr=%h hwrite=%b hready_in=%b -> valid=%b sel=%b hresp=%b rdy=%b",
             cyc, t, a, w, r, valid, temp_sel, hresp, err_readyout);
    model_check();
    model_update();
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
    logic        ev;
    logic [2:0]  es;
    logic [1:0]  eh;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic r, input logic ev, input logic [2:0] es,
                     input logic [1:0] eh, input logic er);
    vec_t v;
    v.t = t; v.a = a; v.d = d; v.w = w; v.r = r;
    v.ev = ev; v.es = es; v.eh = eh; v.er = er;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] a;
    int pick;

    hresetn = 1'b0; htrans = 2'b00; haddr = '0; hwdata = '0; hwrite = 1'b0; hready_in = 1'b1;
    model_reset();
    #12;
    chk("reset_hresp", 32'(hresp), 32'd0);
    chk("reset_readyout", 32'(err_readyout), 32'd1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_haddr2", haddr2, 32'd0);
    chk("reset_hwdata2", hwdata2, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    model_update();

    //   htrans  haddr         hwdata        w  rdy  valid sel     hresp  rdyout
    add(2'b00, 32'h8800_0000, 32'h0,        0, 1,   0, 3'b100, 2'b00, 1); // IDLE
    add(2'b01, 32'h8800_0000, 32'h0,        0, 1,   0, 3'b100, 2'b00, 1); // BUSY
    add(2'b10, 32'h9000_0000, 32'h0,        0, 0,   0, 3'b000, 2'b00, 1); // stalled unmapped
    add(2'b10, 32'h8000_0010, 32'h0,        1, 1,   1, 3'b001, 2'b00, 1); // single write
    add(2'b00, 32'h0000_0000, 32'hA5A5_0001, 0, 1,  0, 3'b000, 2'b00, 1);
    add(2'b10, 32'h8400_0000, 32'h0,        0, 1,   1, 3'b010, 2'b00, 1); // INCR4 read
    add(2'b11, 32'h8400_0004, 32'h0,        0, 1,   1, 3'b010, 2'b00, 1);
    add(2'b11, 32'h8400_0008, 32'h0,        0, 1,   1, 3'b010, 2'b00, 1);
    add(2'b11, 32'h8400_000C, 32'h0,        0, 1,   1, 3'b010, 2'b00, 1);
    add(2'b10, 32'h9000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1); // unmapped
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 0);
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 1);
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1);
    add(2'b10, 32'h9000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1); // back-to-back
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 0);
    add(2'b10, 32'h9000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 1);
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 0);
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 1);
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1);
    add(2'b10, 32'h9000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1); // error ignored in ERR1
    add(2'b10, 32'h9000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 0);
    add(2'b10, 32'h8800_0004, 32'h0,        0, 1,   1, 3'b100, 2'b01, 1); // mapped in ERR2
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1);
    add(2'b10, 32'h9000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1); // mapped in ERR1
    add(2'b10, 32'h8000_0000, 32'h0,        0, 1,   0, 3'b001, 2'b01, 0);
    add(2'b00, 32'h0000_0000, 32'h0,        0, 1,   0, 3'b000, 2'b01, 1);
    add(2'b00, 32'h83FF_FFFC, 32'h0,        0, 1,   0, 3'b001, 2'b00, 1); // window edges
    add(2'b00, 32'h8BFF_FFFF, 32'h0,        0, 1,   0, 3'b100, 2'b00, 1);
    add(2'b00, 32'h8C00_0000, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1);
    add(2'b00, 32'h7FFF_FFFF, 32'h0,        0, 1,   0, 3'b000, 2'b00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_sel", i), 32'(temp_sel), 32'(tbl[i].es));
      chk($sformatf("vec%0d_hresp", i), 32'(hresp), 32'(tbl[i].eh));
      chk($sformatf("vec%0d_rdy", i), 32'(err_readyout), 32'(tbl[i].er));
      if (i == 4) begin
        chk("write_haddr1", haddr1, 32'h8000_0010);
        chk("write_hwrite_reg", 32'(hwrite_reg), 32'd1);
      end
      if (i == 5) begin
        chk("write_haddr2", haddr2, 32'h8000_0010);
        chk("write_hwdata1", hwdata1, 32'hA5A5_0001);
        chk("write_hwrite_reg1", 32'(hwrite_reg1), 32'd1);
      end
      if (i == 8) chk("burst_haddr2", haddr2, 32'h8400_0004);
    end

    // Asynchronous reset landing in the middle of ERR1.
    step(2'b10, 32'h9000_0000, 32'h1234_5678, 1'b1, 1'b1);
    @(posedge hclk);
    #1;
    htrans = 2'b10; haddr = 32'h8000_0000;
    chk("pre_reset_hresp", 32'(hresp), 32'd1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("midrst_hresp", 32'(hresp), 32'd0);
    chk("midrst_readyout", 32'(err_readyout), 32'd1);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_haddr1", haddr1, 32'd0);
    chk("midrst_haddr2", haddr2, 32'd0);
    chk("midrst_hwdata1", hwdata1, 32'd0);
    chk("midrst_hwrite_reg", 32'(hwrite_reg), 32'd0);
    htrans = 2'b00; haddr = '0; hwdata = '0; hwrite = 1'b0;
    model_reset();
    @(negedge hclk);
    hresetn = 1'b1;
    model_update();

    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0, 1, 2: a = 32'(bases[pick]) + ($urandom & 32'h03FF_FFFC);
        3:       a = $urandom;
        4:       a = ($urandom_range(0, 1) == 0) ? 32'(bases[$urandom_range(0, 2)]) - 32'd1
                                                 : 32'(bases[$urandom_range(0, 2)]) + 32'h03FF_FFFF;
        default: a = 32'h9000_0000;
      endcase
      step(2'($urandom), a, $urandom, 1'($urandom),
           ($urandom_range(0, 4) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-side front end of the AHB-to-APB bridge. Sits directly downstream of ahb_master and feeds apb_controller.
- Qualifies AHB address phases into a `valid` strobe and decodes the peripheral select (`temp_sel`).
- Provides two-stage pipelined copies of address, write-data and direction for the controller's address/data-phase alignment.
- Generates the two-cycle AHB ERROR response for unmapped addresses.

Parameters:
- SLV0_BASE, 32'h8000_0000, base of slave 0 window (psel bit 0)
- SLV1_BASE, 32'h8400_0000, base of slave 1 window (psel bit 1)
- SLV2_BASE, 32'h8800_0000, base of slave 2 window (psel bit 2)
- WIN_SIZE, 32'h0400_0000, size of each window in bytes (power of two)

Ports:
- hclk  in  1  bridge clock; all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- hwrite  in  1  AHB direction, 1 = write
- hready_in  in  1  AHB HREADY seen by the bridge (address phase sampled when 1)
- htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- haddr  in  32  AHB address
- hwdata  in  32  AHB write data (data phase)
- valid  out  1  combinational: qualified, mapped transfer in address phase
- temp_sel  out  3  combinational one-hot slave select decoded from haddr
- haddr1, haddr2  out  32  haddr delayed 1 and 2 cycles
- hwdata1, hwdata2  out  32  hwdata delayed 1 and 2 cycles
- hwrite_reg, hwrite_reg1  out  1  hwrite delayed 1 and 2 cycles
- hresp  out  2  AHB response: 00 OKAY, 01 ERROR
- err_readyout  out  1  this block's HREADYOUT contribution; the bridge ANDs it with the controller's hr_readyout

Behaviour:
- Reset (hresetn=0, asynchronous):
  - all pipeline registers clear to 0
  - hresp=00, err_readyout=1, error FSM in OKAY
  - valid forced 0 while in reset
- Pipeline:
  - On every rising edge, independent of hready_in: haddr1<=haddr, haddr2<=haddr1, hwdata1<=hwdata, hwdata2<=hwdata1, hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg.
  - Latency exactly 1 and 2 cycles; apb_controller relies on this free-running timing.
- Decode (combinational):
  - temp_sel = 001 when SLV0_BASE <= haddr < SLV0_BASE+WIN_SIZE.
  - temp_sel = 010 for the SLV1 window, 100 for the SLV2 window, 000 otherwise.
  - Window compare on the upper address bits only, no adders.
- active = hresetn && hready_in && htrans[1] (NONSEQ or SEQ).
- valid = active && (temp_sel != 0) && (state != ERR1). BUSY and IDLE never assert valid.
- err_req = active && (temp_sel == 0).
- Error FSM (states OKAY, ERR1, ERR2, registered):
  - OKAY: hresp=00, err_readyout=1. Goes to ERR1 on a rising edge where err_req=1, else stays.
  - ERR1: hresp=01, err_readyout=0. Goes to ERR2 unconditionally.
  - ERR2: hresp=01, err_readyout=1. Goes to ERR1 if err_req (back-to-back error), else to OKAY.
  - hresp and err_readyout are decoded from state only (Moore), no combinational path from inputs.
- Mapped transfer sampled in ERR2: valid=1 and the FSM returns to OKAY. The AHB master is expected to cancel with IDLE, but this case is legal.
- hready_in=0: no address phase is sampled; the FSM holds in OKAY; ERR1->ERR2->OKAY still proceeds.
- Reset asserted mid-error returns to OKAY immediately (asynchronous); hresp goes to 00 in the same cycle.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants
  - the error FSM state encoding
  - default slave base addresses and WIN_SIZE
- One natural sub-module, ahb_addr_decode: combinational haddr-to-temp_sel, reused by any future slave-count variants. Everything else stays in ahb_slave_if.

Test Plan:
- Reset mid-transfer:
  - Stimulus: drive hresetn=0 at a non-clock-edge time during ERR1.
  - Required: hresp=00, err_readyout=1 and all pipeline outputs 0 immediately; valid=0.
- Single write:
  - Stimulus: NONSEQ, haddr=32'h8000_0010, hwrite=1, hready_in=1; next cycle hwdata=32'hA5A5_0001.
  - Required: valid=1 and temp_sel=001 in the address cycle.
  - Required: after edge 1, haddr1=8000_0010, hwrite_reg=1.
  - Required: after edge 2, haddr2=8000_0010, hwdata1=A5A5_0001, hwrite_reg1=1.
- INCR4 read burst:
  - Stimulus: NONSEQ 8400_0000, then SEQ 8400_0004/08/0C, hwrite=0.
  - Required: valid=1 each beat, temp_sel=010, haddr2 trails haddr by exactly 2 cycles, hresp stays 00.
- Unmapped address:
  - Stimulus: NONSEQ, haddr=32'h9000_0000, hready_in=1, then IDLE.
  - Required: valid=0, temp_sel=000.
  - Required: next cycle hresp=01, err_readyout=0; following cycle hresp=01, err_readyout=1; then 00/1.
- IDLE, BUSY and stalled phases:
  - Stimulus: IDLE and BUSY with haddr=8800_0000; also NONSEQ 9000_0000 with hready_in=0.
  - Required: valid=0, no ERROR response, temp_sel=100 and 000 respectively.
- Back-to-back error:
  - Stimulus: a second unmapped NONSEQ sampled during ERR2.
  - Required: FSM goes ERR2->ERR1, giving hresp=01 for four consecutive cycles with err_readyout pattern 0,1,0,1.
